// File: rtl/stopwatch_fnd_ctrl.sv
// Purpose: scans stopwatch sec/msec onto a 4-digit common-anode 7-segment display as SS.mm, with the dp blinking at 1 Hz.
// Latency: one cycle from digit_sel/shadow to fnd_com/fnd_data; time inputs are snapshotted once per scan frame.
// Backpressure: none, the inputs are sampled only at the D3->D0 wrap. Define FND_LEADING_ZERO_BLANK_EN to blank a leading zero in the sec tens digit.
module stopwatch_fnd_ctrl #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DP_BLINK_SPLIT = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } digit_t;

    logic [CNT_W-1:0] scan_cnt;
    logic             scan_tick;
    digit_t           digit_sel;
    logic [6:0]       shadow_msec;
    logic [5:0]       shadow_sec;
    logic [3:0]       msec_tens, msec_ones, sec_tens, sec_ones;
    logic [3:0]       digit_val;
    logic             dp_on;
    logic [7:0]       seg_next;

    // Segment pattern g..a, active-low, without the dp bit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign scan_tick = (scan_cnt == CNT_W'(SCAN_DIV - 1));

    assign msec_tens = 4'(shadow_msec / 7'd10);
    assign msec_ones = 4'(shadow_msec % 7'd10);
    assign sec_tens  = 4'(shadow_sec / 6'd10);
    assign sec_ones  = 4'(shadow_sec % 6'd10);

    assign dp_on = (digit_sel == D2) && (shadow_msec < 7'(DP_BLINK_SPLIT));

    always_comb begin
        digit_val = 4'd0;
        case (digit_sel)
            D0: digit_val = msec_ones;
            D1: digit_val = msec_tens;
            D2: digit_val = sec_ones;
            D3: digit_val = sec_tens;
            default: digit_val = 4'd0;
        endcase
        seg_next = {~dp_on, seg7(digit_val)};
`ifdef FND_LEADING_ZERO_BLANK_EN
        // Digit stays enabled while blanked so every digit keeps the same duty cycle.
        if (digit_sel == D3 && sec_tens == 4'd0) begin
            seg_next = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt    <= '0;
            digit_sel   <= D0;
            shadow_msec <= 7'd0;
            shadow_sec  <= 6'd0;
            fnd_com     <= 4'b1111;
            fnd_data    <= 8'hFF;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
            if (scan_tick) begin
                case (digit_sel)
                    D0: digit_sel <= D1;
                    D1: digit_sel <= D2;
                    D2: digit_sel <= D3;
                    D3: begin
                        // Whole-frame snapshot so a frame never shows a torn value.
                        digit_sel   <= D0;
                        shadow_msec <= (msec > 7'd99) ? 7'd99 : msec;
                        shadow_sec  <= (sec > 6'd59) ? 6'd59 : sec;
                    end
                    default: digit_sel <= D0;
                endcase
            end
            fnd_com  <= ~(4'b0001 << digit_sel);
            fnd_data <= seg_next;
        end
    end
endmodule

// File: tb/tb_stopwatch_fnd_ctrl.sv
// Directed bench for stopwatch_fnd_ctrl with a 4-cycle scan period per digit.
module tb_stopwatch_fnd_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int checks = 0;
    int errors = 0;

    stopwatch_fnd_ctrl #(
        .CLK_HZ(4),
        .SCAN_HZ(1),
        .DP_BLINK_SPLIT(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .msec(msec),
        .sec(sec),
        .fnd_com(fnd_com),
        .fnd_data(fnd_data)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_com, input logic [7:0] exp_data);
        checks++;
        assert (fnd_com === exp_com) else begin
            errors++;
            $error("FAIL %s fnd_com got %b exp %b", tag, fnd_com, exp_com);
        end
        checks++;
        assert (fnd_data === exp_data) else begin
            errors++;
            $error("FAIL %s fnd_data got %h exp %h", tag, fnd_data, exp_data);
        end
    endtask

    logic [7:0] exp_f2 [4];
    logic [3:0] com_of [4];
    logic [7:0] blank_d3_zero;

    initial begin
        exp_f2[0] = 8'hF8;
        exp_f2[1] = 8'hB0;
        exp_f2[2] = 8'h24;
        exp_f2[3] = 8'h99;
        com_of[0] = 4'b1110;
        com_of[1] = 4'b1101;
        com_of[2] = 4'b1011;
        com_of[3] = 4'b0111;
`ifdef FND_LEADING_ZERO_BLANK_EN
        blank_d3_zero = 8'hFF;
`else
        blank_d3_zero = 8'hC0;
`endif

        rst  = 1'b0;
        msec = 7'd37;
        sec  = 6'd42;
        step(3);
        chk("reset", 4'b1111, 8'hFF);

        rst = 1'b1;
        step(1);
        chk("first_d0", 4'b1110, 8'hC0);
        step(15);
        chk("frame1_d3", 4'b0111, blank_d3_zero);

        // Second frame shows 42.37: dp on at D2 since 37 < 50.
        step(1);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("f2_d%0d_first", d), com_of[d], exp_f2[d]);
            step(3);
            chk($sformatf("f2_d%0d_last", d), com_of[d], exp_f2[d]);
            step(1);
        end

        // Load 12.34, then change msec mid-frame.
        msec = 7'd34;
        sec  = 6'd12;
        step(16);
        chk("f4_d0", 4'b1110, 8'h99);
        step(4);
        chk("f4_d1", 4'b1101, 8'hB0);
        msec = 7'd88;
        step(4);
        chk("f4_d2_old", 4'b1011, 8'h24);
        step(4);
        chk("f4_d3_old", 4'b0111, 8'hF9);
        step(4);
        chk("f5_d0_new", 4'b1110, 8'h80);
        step(4);
        chk("f5_d1_new", 4'b1101, 8'h80);
        step(4);
        chk("f5_d2_dpoff", 4'b1011, 8'hA4);

        // Clamp: 63/120 displays 59.99.
        msec = 7'd120;
        sec  = 6'd63;
        step(4);
        chk("f5_d3", 4'b0111, 8'hF9);
        step(4);
        chk("clamp_d0", 4'b1110, 8'h90);
        step(4);
        chk("clamp_d1", 4'b1101, 8'h90);
        step(4);
        chk("clamp_d2", 4'b1011, 8'h90);
        step(4);
        chk("clamp_d3", 4'b0111, 8'h92);

        // 05.49: dp on, leading zero at D3.
        msec = 7'd49;
        sec  = 6'd5;
        step(4);
        chk("m49_d0", 4'b1110, 8'h90);
        step(4);
        chk("m49_d1", 4'b1101, 8'h99);
        step(4);
        chk("m49_d2_dpon", 4'b1011, 8'h12);
        step(4);
        chk("m49_d3_lead", 4'b0111, blank_d3_zero);

        // 05.50: dp off.
        msec = 7'd50;
        step(4);
        chk("m50_d0", 4'b1110, 8'hC0);
        step(8);
        chk("m50_d2_dpoff", 4'b1011, 8'h92);

        // Reset mid-D2.
        rst = 1'b0;
        step(1);
        chk("midreset", 4'b1111, 8'hFF);
        rst = 1'b1;
        step(1);
        chk("restart_d0", 4'b1110, 8'hC0);
        step(8);
        chk("restart_d2_zero", 4'b1011, 8'h40);
        step(12);
        chk("restart_snap_d1", 4'b1101, 8'h92);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
